// File: rtl/shift_by_reg_sequencer_if.sv
// Request/response bundle between the datapath control unit and the
// shift-by-register sequencer.
interface shift_by_reg_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
);
    logic              start;
    logic              flush;
    logic [1:0]        shift_type;
    logic [AMT_W-1:0]  amount;
    logic [DATA_W-1:0] rm;
    logic              c_in;
    logic [DATA_W-1:0] result;
    logic              shift_cout;
    logic              busy;
    logic              done;

    modport master (
        output start, flush, shift_type, amount, rm, c_in,
        input  result, shift_cout, busy, done
    );

    modport slave (
        input  start, flush, shift_type, amount, rm, c_in,
        output result, shift_cout, busy, done
    );
endinterface

// File: rtl/shift_by_reg_sequencer.sv
// Multi-cycle "shift by register" operand generator: shifts Rm by Rs[7:0]
// one bit per cycle and returns the shifter operand and carry-out.
module shift_by_reg_sequencer #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    shift_by_reg_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int ROT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    shift_t            type_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  k_start;
    logic [DATA_W-1:0] result_q;
    logic              cout_q;
    logic              load;
    logic              step;

    // LSL/LSR saturate one past the width so the final step clears the carry;
    // ROR by a nonzero multiple of the width still does a full rotation.
    function automatic logic [CNT_W-1:0] eff_count(input shift_t t,
                                                   input logic [AMT_W-1:0] a);
        logic [CNT_W-1:0] k;
        logic [ROT_W-1:0] low;
        k   = '0;
        low = a[ROT_W-1:0];
        if (a != '0) begin
            case (t)
                SH_LSL, SH_LSR:
                    k = (a > AMT_W'(DATA_W + 1)) ? CNT_W'(DATA_W + 1) : CNT_W'(a);
                SH_ASR:
                    k = (a > AMT_W'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(a);
                default:
                    k = (low == '0) ? CNT_W'(DATA_W) : CNT_W'(low);
            endcase
        end
        return k;
    endfunction

    // One-bit shift; returns {carry_out, shifted_value}.
    function automatic logic [DATA_W:0] shift_step(input shift_t t,
                                                   input logic [DATA_W-1:0] r);
        logic signed [DATA_W-1:0] s;
        logic [DATA_W-1:0]        asr;
        logic [DATA_W:0]          res;
        s   = signed'(r);
        asr = s >>> 1;
        case (t)
            SH_LSL:  res = {r[DATA_W-1], r[DATA_W-2:0], 1'b0};
            SH_LSR:  res = {r[0], 1'b0, r[DATA_W-1:1]};
            SH_ASR:  res = {r[0], asr};
            default: res = {r[0], r[0], r[DATA_W-1:1]};
        endcase
        return res;
    endfunction

    assign k_start = eff_count(shift_t'(bus.shift_type), bus.amount);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    load       = 1'b1;
                    state_next = (k_start == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            type_q   <= SH_LSL;
            count    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (load) begin
            type_q   <= shift_t'(bus.shift_type);
            count    <= k_start;
            result_q <= bus.rm;
            cout_q   <= bus.c_in;
        end else if (step) begin
            {cout_q, result_q} <= shift_step(type_q, result_q);
            count              <= count - CNT_W'(1);
        end
    end

    assign bus.result     = result_q;
    assign bus.shift_cout = cout_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_shift_by_reg_sequencer.sv
// Directed self-checking bench for shift_by_reg_sequencer.
module tb_shift_by_reg_sequencer;
    logic clk;
    logic reset_n;
    int   tests;
    int   failed;

    shift_by_reg_sequencer_if #(.DATA_W(32), .AMT_W(8)) bus ();

    shift_by_reg_sequencer #(.DATA_W(32), .AMT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and advance to the edge where it is accepted (+1).
    task automatic issue(input logic [1:0] t, input logic [7:0] a,
                         input logic [31:0] r, input logic ci);
        @(negedge clk);
        bus.shift_type = t;
        bus.amount     = a;
        bus.rm         = r;
        bus.c_in       = ci;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] r, input logic ci,
                          input logic [31:0] er, input logic ec, input int el);
        int cyc;
        issue(t, a, r, ci);
        cyc = 1;
        bus.rm         = ~r;
        bus.amount     = a + 8'd1;
        bus.c_in       = ~ci;
        bus.shift_type = ~t;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, el);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_cout"}, {31'd0, bus.shift_cout}, {31'd0, ec});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        check({tag, "_held"}, bus.result, er);
    endtask

    initial begin
        int seen;
        int cyc;
        tests      = 0;
        failed     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.shift_type = 2'b00;
        bus.amount = 8'd0;
        bus.rm     = 32'd0;
        bus.c_in   = 1'b0;
        #12;
        check("reset_state", {bus.result[29:0], bus.shift_cout, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("lsl1",     2'b00, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2);
        run_op("lsl32",    2'b00, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33);
        run_op("lsr32",    2'b01, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 33);
        run_op("lsr200",   2'b01, 8'd200, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 34);
        run_op("lsr4",     2'b01, 8'd4,   32'hF000_0018, 1'b0, 32'h0F00_0001, 1'b1, 5);
        run_op("asr40",    2'b10, 8'd40,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("asr0",     2'b10, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);
        run_op("asr4pos",  2'b10, 8'd4,   32'h7000_0008, 1'b1, 32'h0700_0000, 1'b1, 5);
        run_op("ror4",     2'b11, 8'd4,   32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0, 5);
        run_op("ror36",    2'b11, 8'd36,  32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0, 5);
        run_op("ror32",    2'b11, 8'd32,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 33);

        // start while busy must be ignored and not queued
        issue(2'b00, 8'd3, 32'h0000_0001, 1'b0);
        cyc = 1;
        @(negedge clk);
        bus.shift_type = 2'b01;
        bus.amount     = 8'd1;
        bus.rm         = 32'hFFFF_FFFF;
        bus.c_in       = 1'b1;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc++;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_start_latency", cyc, 4);
        check("busy_start_result", bus.result, 32'h0000_0008);
        check("busy_start_cout", {31'd0, bus.shift_cout}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("busy_start_not_queued", {30'd0, bus.busy, bus.done}, 32'd0);

        // flush together with start in IDLE is not accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_blocks_start", {31'd0, bus.busy}, 32'd0);

        // flush mid-SHIFT
        issue(2'b00, 8'd10, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_to_idle", {31'd0, bus.busy}, 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("flush_no_done", seen, 0);

        // asynchronous reset mid-SHIFT
        issue(2'b01, 8'd20, 32'hF000_0000, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_result", bus.result, 32'd0);
        check("areset_ctrl", {29'd0, bus.busy, bus.done, bus.shift_cout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("after_reset", 2'b00, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
